pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: tracks post-decode stages and produces forwarding selects,
// load-use stalls and PC-redirect flushes with saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int ADDRESSWIDTH = 4,
    parameter int STAGES = 3,
    parameter int LOAD_READY_STAGE = 3,
    parameter int CNTWIDTH = 16,
    localparam int SELWIDTH = $clog2(STAGES + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issueValidD,
    input  logic                    writeEnableD,
    input  logic                    isLoadD,
    input  logic                    writesPCD,
    input  logic                    usesReg1D,
    input  logic                    usesReg2D,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressD,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressD,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressD,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    flushD,
    output logic                    flushE,
    output logic [SELWIDTH-1:0]     data1ForwardSelectorE,
    output logic [SELWIDTH-1:0]     data2ForwardSelectorE,
    output logic [STAGES-1:0]       stageValid,
    output logic [CNTWIDTH-1:0]     stallCount,
    output logic [CNTWIDTH-1:0]     flushCount
);
    logic [STAGES:1]         r_vld, r_we, r_ld, r_pc;
    logic [ADDRESSWIDTH-1:0] r_dst [STAGES:1];
    logic [ADDRESSWIDTH-1:0] r_src1, r_src2;
    logic                    r_use1, r_use2;
    logic [CNTWIDTH-1:0]     r_scnt, r_fcnt;
    logic                    w_redirect, w_hit, w_stall;
    logic [SELWIDTH-1:0]     w_sel1, w_sel2;

    assign w_redirect = r_vld[STAGES] & r_pc[STAGES];
    assign w_stall    = issueValidD & ~w_redirect & w_hit;

    // Selector loop runs oldest-to-youngest so the youngest matching producer wins.
    always_comb begin
        w_hit  = 1'b0;
        w_sel1 = '0;
        w_sel2 = '0;
        for (int j = 1; j <= STAGES; j++)
            if (j + 1 < LOAD_READY_STAGE && r_vld[j] && r_we[j] && r_ld[j] &&
                ((usesReg1D && r_dst[j] == reg1AddressD) || (usesReg2D && r_dst[j] == reg2AddressD)))
                w_hit = 1'b1;
        for (int k = STAGES; k >= 2; k--) begin
            if (r_vld[1] && r_use1 && r_vld[k] && r_we[k] && r_dst[k] == r_src1)
                w_sel1 = SELWIDTH'(k);
            if (r_vld[1] && r_use2 && r_vld[k] && r_we[k] && r_dst[k] == r_src2)
                w_sel2 = SELWIDTH'(k);
        end
    end

    assign stallF                = w_stall;
    assign stallD                = w_stall;
    assign flushD                = w_redirect;
    assign flushE                = w_stall | w_redirect;
    assign data1ForwardSelectorE = w_sel1;
    assign data2ForwardSelectorE = w_sel2;
    assign stageValid            = r_vld;
    assign stallCount            = r_scnt;
    assign flushCount            = r_fcnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld  <= '0;
            r_we   <= '0;
            r_ld   <= '0;
            r_pc   <= '0;
            for (int k = 1; k <= STAGES; k++)
                r_dst[k] <= '0;
            r_src1 <= '0;
            r_src2 <= '0;
            r_use1 <= 1'b0;
            r_use2 <= 1'b0;
            r_scnt <= '0;
            r_fcnt <= '0;
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_we[k]  <= r_we[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_pc[k]  <= r_pc[k-1];
                r_dst[k] <= r_dst[k-1];
            end
            // A stalled decode instruction leaves an all-zero bubble in Execute.
            r_vld[1] <= issueValidD & ~w_stall;
            r_we[1]  <= writeEnableD & ~w_stall;
            r_ld[1]  <= isLoadD & ~w_stall;
            r_pc[1]  <= writesPCD & ~w_stall;
            r_dst[1] <= w_stall ? '0 : regDestinationAddressD;
            r_src1   <= w_stall ? '0 : reg1AddressD;
            r_src2   <= w_stall ? '0 : reg2AddressD;
            r_use1   <= usesReg1D & ~w_stall;
            r_use2   <= usesReg2D & ~w_stall;
            if (w_redirect) begin
                r_vld  <= '0;
                r_we   <= '0;
                r_ld   <= '0;
                r_pc   <= '0;
                for (int k = 1; k <= STAGES; k++)
                    r_dst[k] <= '0;
                r_src1 <= '0;
                r_src2 <= '0;
                r_use1 <= 1'b0;
                r_use2 <= 1'b0;
            end
            if (w_stall && ~&r_scnt)
                r_scnt <= r_scnt + CNTWIDTH'(1);
            if (w_redirect && ~&r_fcnt)
                r_fcnt <= r_fcnt + CNTWIDTH'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed hazard scenarios plus random traffic checked
// against a queue-based pipeline model.
module tb_pipeline_hazard_ctrl;
    localparam int STG = 3;
    localparam int LRS = 3;

    typedef struct {
        bit       v, we, ld, pc, u1, u2;
        bit [3:0] a1, a2, d;
    } ent_t;

    logic       clk, rst;
    logic       iv, we, ld, pc, u1, u2;
    logic [3:0] a1, a2, d;
    logic       sf, sd, fd, fe, sf2, sd2, fd2, fe2;
    logic [1:0] s1, s2, s1b, s2b;
    logic [2:0] sv, sv2;
    logic [15:0] scnt, fcnt;
    logic [1:0]  scnt2, fcnt2;

    int   n_cmp = 0, n_err = 0;
    ent_t pipe[$];
    int   m_s = 0, m_f = 0;
    bit   last_stall;

    pipeline_hazard_ctrl #(.ADDRESSWIDTH(4), .STAGES(STG), .LOAD_READY_STAGE(LRS), .CNTWIDTH(16)) dut (
        .clock(clk), .reset(rst), .issueValidD(iv), .writeEnableD(we), .isLoadD(ld), .writesPCD(pc),
        .usesReg1D(u1), .usesReg2D(u2), .reg1AddressD(a1), .reg2AddressD(a2), .regDestinationAddressD(d),
        .stallF(sf), .stallD(sd), .flushD(fd), .flushE(fe),
        .data1ForwardSelectorE(s1), .data2ForwardSelectorE(s2),
        .stageValid(sv), .stallCount(scnt), .flushCount(fcnt));

    pipeline_hazard_ctrl #(.ADDRESSWIDTH(4), .STAGES(STG), .LOAD_READY_STAGE(LRS), .CNTWIDTH(2)) dut2 (
        .clock(clk), .reset(rst), .issueValidD(iv), .writeEnableD(we), .isLoadD(ld), .writesPCD(pc),
        .usesReg1D(u1), .usesReg2D(u2), .reg1AddressD(a1), .reg2AddressD(a2), .regDestinationAddressD(d),
        .stallF(sf2), .stallD(sd2), .flushD(fd2), .flushE(fe2),
        .data1ForwardSelectorE(s1b), .data2ForwardSelectorE(s2b),
        .stageValid(sv2), .stallCount(scnt2), .flushCount(fcnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(bit v, bit w, bit l, bit p, bit x1, bit x2, bit [3:0] r1, bit [3:0] r2, bit [3:0] rd);
        ent_t e;
        e.v = v; e.we = w; e.ld = l; e.pc = p; e.u1 = x1; e.u2 = x2; e.a1 = r1; e.a2 = r2; e.d = rd;
        return e;
    endfunction

    function automatic bit hits(ent_t e, bit [3:0] a);
        return e.v && e.we && e.d == a;
    endfunction

    function automatic int fwd(bit used, bit [3:0] a);
        if (!pipe[0].v || !used) return 0;
        for (int k = 1; k < STG; k++)
            if (hits(pipe[k], a)) return k + 1;
        return 0;
    endfunction

    task automatic clear_model();
        pipe.delete();
        for (int k = 0; k < STG; k++) pipe.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_s = 0;
        m_f = 0;
        last_stall = 0;
    endtask

    task automatic apply(input ent_t x);
        iv = x.v; we = x.we; ld = x.ld; pc = x.pc; u1 = x.u1; u2 = x.u2; a1 = x.a1; a2 = x.a2; d = x.d;
    endtask

    // One decode cycle: drive at the falling edge, compare, then advance the model.
    task automatic step(input ent_t x);
        bit redir, hit, stall;
        int e1, e2;
        @(negedge clk);
        apply(x);
        #1;
        redir = pipe[STG-1].v && pipe[STG-1].pc;
        hit = 0;
        for (int j = 0; j < STG; j++)
            if (j + 2 < LRS && pipe[j].ld && ((x.u1 && hits(pipe[j], x.a1)) || (x.u2 && hits(pipe[j], x.a2))))
                hit = 1;
        stall = x.v && !redir && hit;
        e1 = fwd(pipe[0].u1, pipe[0].a1);
        e2 = fwd(pipe[0].u2, pipe[0].a2);
        chk("stallF", sf, stall);
        chk("stallD", sd, stall);
        chk("flushD", fd, redir);
        chk("flushE", fe, stall || redir);
        chk("sel1", s1, e1);
        chk("sel2", s2, e2);
        chk("stageValid", sv, {pipe[2].v, pipe[1].v, pipe[0].v});
        chk("stallCount", scnt, m_s);
        chk("flushCount", fcnt, m_f);
        chk("stallCount_sat", scnt2, m_s > 3 ? 3 : m_s);
        chk("flushCount_sat", fcnt2, m_f > 3 ? 3 : m_f);
        chk("ld_fwd1", (s1 != 0 && s1 < LRS && pipe[s1-1].ld), 0);
        chk("ld_fwd2", (s2 != 0 && s2 < LRS && pipe[s2-1].ld), 0);
        if (redir) begin
            foreach (pipe[k]) pipe[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            pipe.push_front(stall ? mk(0, 0, 0, 0, 0, 0, 0, 0, 0) : x);
            void'(pipe.pop_back());
        end
        if (stall) m_s++;
        if (redir) m_f++;
        last_stall = stall;
    endtask

    task automatic drain();
        repeat (STG) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    function automatic ent_t rnd();
        return mk($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    endfunction

    initial begin
        ent_t x;
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_valid", sv, 0);
        chk("rst_stall", scnt, 0);
        rst = 1'b0;

        repeat (40) step(rnd());
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 5));
        step(mk(1, 0, 0, 0, 1, 0, 5, 0, 0));
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", sv, 0);
        chk("rst_mid_outs", {sf, sd, fd, fe, s1, s2}, 0);
        chk("rst_mid_cnt", {scnt, fcnt}, 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        clear_model();

        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 3));
        step(mk(1, 1, 0, 0, 1, 0, 3, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("alu_b2b_sel", s1, 2);
        chk("alu_b2b_nostall", sf, 0);
        drain();

        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 7));
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 7));
        step(mk(1, 0, 0, 0, 1, 0, 7, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("youngest_sel", s1, 2);
        drain();
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 7));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 1, 0, 7, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("oldest_only_sel", s2, 3);
        drain();

        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 5));
        step(mk(1, 0, 0, 0, 1, 0, 5, 0, 0));
        chk("lu_stall", {sf, sd, fe, fd}, 4'b1110);
        step(mk(1, 0, 0, 0, 1, 0, 5, 0, 0));
        chk("lu_count", scnt, 1);
        chk("lu_released", sf, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("lu_sel", s1, 3);
        drain();

        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 5));
        step(mk(1, 0, 0, 0, 1, 0, 5, 0, 0));
        chk("redir_flush", {fd, fe, sf, sd}, 4'b1100);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("redir_valid", sv, 0);
        chk("redir_count", fcnt, 1);
        chk("redir_nostall_count", scnt, 1);

        x = rnd();
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) x = rnd();
            step(x);
        end
        chk("sat_hold", scnt2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
